// File: rtl/snn_sram_pkg.sv
// Shared definitions for the synaptic weight SRAM controller.
//   op_e     : request opcode (READ fetch / UPDATE read-modify-write)
//   state_e  : controller FSM states
//   nlane()  : number of weight lanes packed into one SRAM word
package snn_sram_pkg;

    typedef enum logic {
        OP_READ   = 1'b0,
        OP_UPDATE = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_RSP  = 3'd3,
        ST_WR   = 3'd4
    } state_e;

    // DATA_WIDTH must be an exact multiple of WEIGHT_WIDTH; any remainder
    // bits of the word would otherwise be left undriven on the write path.
    function automatic int nlane(input int data_width, input int weight_width);
        return data_width / weight_width;
    endfunction

endpackage

// File: rtl/weight_sat_add.sv
// One weight lane: signed weight + signed delta, saturated to the lane range.
// Ports:
//   weight  in   WEIGHT_WIDTH  current signed weight
//   delta   in   WEIGHT_WIDTH  signed increment
//   result  out  WEIGHT_WIDTH  clamp(weight + delta, -2^(W-1), 2^(W-1)-1)
module weight_sat_add #(
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic [WEIGHT_WIDTH-1:0] weight,
    input  logic [WEIGHT_WIDTH-1:0] delta,
    output logic [WEIGHT_WIDTH-1:0] result
);

    localparam logic [WEIGHT_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    localparam logic [WEIGHT_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

    logic [WEIGHT_WIDTH:0] sum;

    // One extra bit of headroom; the sum overflowed the lane exactly when the
    // two top bits disagree, and the top bit then tells the direction.
    assign sum = {weight[WEIGHT_WIDTH-1], weight} + {delta[WEIGHT_WIDTH-1], delta};

    always_comb begin
        result = sum[WEIGHT_WIDTH-1:0];
        if (sum[WEIGHT_WIDTH] != sum[WEIGHT_WIDTH-1]) begin
            result = sum[WEIGHT_WIDTH] ? W_MIN : W_MAX;
        end
    end

endmodule

// File: rtl/sram_synaptic_rmw_ctrl.sv
// Synaptic weight SRAM initiator: serves weight fetches and saturating
// read-modify-write weight updates, one request in flight.
// Ports:
//   CK, RST                     clock / synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_op                      0 = READ, 1 = UPDATE
//   req_addr                    word address (>= SRAM_DEPTH is dropped, err_oor pulses)
//   req_mask, req_delta         UPDATE lane mask and signed delta
//   rsp_valid/rsp_ready         READ response handshake
//   rsp_data                    READ data word
//   err_oor                     1-cycle pulse for a dropped out-of-range request
//   busy                        controller not idle
//   CS, WE, A, D                registered SRAM controls and write data
//   Q                           SRAM read data, valid the cycle after a read strobe
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; only state with req_ready high
// RD      | read strobe on the SRAM (CS=1 WE=0)
// CAP     | Q valid: capture word, compute updated word
// RSP     | READ data presented until rsp_ready
// WR      | write strobe with the updated word (CS=1 WE=1)
module sram_synaptic_rmw_ctrl
    import snn_sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int SRAM_DEPTH   = 256,
    parameter int WEIGHT_WIDTH = 8,
    localparam int NLANE       = nlane(DATA_WIDTH, WEIGHT_WIDTH)
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [NLANE-1:0]        req_mask,
    input  logic [WEIGHT_WIDTH-1:0] req_delta,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    err_oor,
    output logic                    busy,
    output logic                    CS,
    output logic                    WE,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);

    // One extra bit so a depth equal to 2^ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(SRAM_DEPTH);

    state_e                  state;
    op_e                     op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [NLANE-1:0]        mask_q;
    logic [WEIGHT_WIDTH-1:0] delta_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [DATA_WIDTH-1:0]   new_word;
    logic                    req_oor;

    assign req_ready = (state == ST_IDLE) && !RST;
    assign busy      = (state != ST_IDLE);
    assign rsp_data  = word_q;
    assign req_oor   = ({1'b0, req_addr} >= DEPTH_LIM);

    // Updated word is built straight from Q during CAP so the write can be
    // issued on the very next cycle.
    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        logic [WEIGHT_WIDTH-1:0] lane_sat;

        weight_sat_add #(
            .WEIGHT_WIDTH (WEIGHT_WIDTH)
        ) u_sat (
            .weight (Q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .delta  (delta_q),
            .result (lane_sat)
        );

        assign new_word[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
            mask_q[i] ? lane_sat : Q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            mask_q    <= '0;
            delta_q   <= '0;
            word_q    <= '0;
            rsp_valid <= 1'b0;
            err_oor   <= 1'b0;
            CS        <= 1'b0;
            WE        <= 1'b0;
            A         <= '0;
            D         <= '0;
        end else begin
            err_oor <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_e'(req_op);
                        addr_q  <= req_addr;
                        mask_q  <= req_mask;
                        delta_q <= req_delta;
                        if (req_oor) begin
                            err_oor <= 1'b1;
                        end else begin
                            state <= ST_RD;
                            CS    <= 1'b1;
                            WE    <= 1'b0;
                            A     <= req_addr;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                    CS    <= 1'b0;
                end
                ST_CAP: begin
                    word_q <= Q;
                    if (op_q == OP_READ) begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                    end else if (mask_q != '0) begin
                        state <= ST_WR;
                        CS    <= 1'b1;
                        WE    <= 1'b1;
                        A     <= addr_q;
                        D     <= new_word;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                ST_WR: begin
                    state <= ST_IDLE;
                    CS    <= 1'b0;
                    WE    <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    CS        <= 1'b0;
                    WE        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_synaptic_rmw_ctrl.sv
// Bench for sram_synaptic_rmw_ctrl with a behavioural SRAM and a word-level
// reference memory updated by plain integer lane arithmetic.
module tb_sram_synaptic_rmw_ctrl;

    localparam int AW = 9;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [7:0]  req_delta = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        err_oor;
    logic        busy;
    logic        CS;
    logic        WE;
    logic [8:0]  A;
    logic [31:0] D;
    logic [31:0] Q = '0;

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, hs_cnt = 0, we_cnt = 0, cs_cnt = 0, err_cnt = 0, rsp_cnt = 0;
    int last_hs_cyc = 0;

    sram_synaptic_rmw_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (32),
        .SRAM_DEPTH   (256),
        .WEIGHT_WIDTH (8)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_delta (req_delta),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .err_oor   (err_oor),
        .busy      (busy),
        .CS        (CS),
        .WE        (WE),
        .A         (A),
        .D         (D),
        .Q         (Q)
    );

    always #5 CK = ~CK;

    // Behavioural SRAM: write or 1-cycle registered read on CS.
    always @(posedge CK) begin
        if (CS === 1'b1) begin
            if (WE === 1'b1) mem[A] = D;
            else             Q <= mem[A];
        end
    end

    always @(posedge CK) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready === 1'b1) begin
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
        if (CS === 1'b1 && WE === 1'b1) we_cnt <= we_cnt + 1;
        if (CS === 1'b1) cs_cnt <= cs_cnt + 1;
        if (err_oor === 1'b1) err_cnt <= err_cnt + 1;
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Reference lane rule: each masked lane becomes clamp(w + delta) in [-128,127].
    function automatic logic [31:0] ref_update(input logic [31:0] w, input logic [3:0] m,
                                               input logic [7:0] d);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                int s;
                s = int'($signed(w[i*8 +: 8])) + int'($signed(d));
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                r[i*8 +: 8] = s[7:0];
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Presents a request and returns #1 after the accepting edge.
    task automatic issue(input logic op, input logic [8:0] addr, input logic [3:0] mask,
                         input logic [7:0] delta);
        int t;
        req_op = op; req_addr = addr; req_mask = mask; req_delta = delta;
        req_valid = 1'b1;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, t);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 20) begin
            step();
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        n_cmp++;
        if ({CS, WE, rsp_valid, busy, err_oor} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: CS/WE/rsp_valid/busy/err=%b, required 00000",
                     {CS, WE, rsp_valid, busy, err_oor});
        end
        n_cmp++;
        if (A !== 9'd0 || D !== 32'd0 || rsp_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: A=%h D=%h rsp_data=%h, required 0", A, D, rsp_data);
        end
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_in_rst: req_ready=%b, required 0", req_ready);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_read_hold();
        rsp_ready = 1'b0;
        issue(1'b0, 9'd5, 4'h0, 8'h00);
        n_cmp++;
        if (CS !== 1'b1 || WE !== 1'b0 || A !== 9'd5 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL read_rd_cycle: CS=%b WE=%b A=%0d rsp_valid=%b req_ready=%b, required 1 0 5 0 0",
                     CS, WE, A, rsp_valid, req_ready);
        end
        step();
        n_cmp++;
        if (CS !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_cap_cycle: CS=%b rsp_valid=%b, required 0 0", CS, rsp_valid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h7F80_0102 || req_ready !== 1'b0 || CS !== 1'b0) begin
                n_err++;
                $display("FAIL read_hold[%0d]: rsp_valid=%b rsp_data=%h req_ready=%b CS=%b, required 1 7f800102 0 0",
                         k, rsp_valid, rsp_data, req_ready, CS);
            end
            if (k < 3) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_handshake: rsp_valid=%b req_ready=%b busy=%b, required 0 1 0",
                     rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_update();
        int we0;
        issue(1'b1, 9'd5, 4'b1111, 8'sd2);
        step();
        step();
        n_cmp++;
        if (CS !== 1'b1 || WE !== 1'b1 || A !== 9'd5 || D !== 32'h7F82_0304) begin
            n_err++;
            $display("FAIL update_wr_cycle: CS=%b WE=%b A=%0d D=%h, required 1 1 5 7f820304", CS, WE, A, D);
        end
        step();
        ref_mem[5] = ref_update(ref_mem[5], 4'b1111, 8'sd2);
        n_cmp++;
        if (busy !== 1'b0 || mem[5] !== 32'h7F82_0304 || mem[5] !== ref_mem[5]) begin
            n_err++;
            $display("FAIL update_sat_hi: busy=%b mem[5]=%h, required 0 7f820304 (model %h)",
                     busy, mem[5], ref_mem[5]);
        end
        issue(1'b1, 9'd5, 4'b0100, -8'sd3);
        wait_idle();
        ref_mem[5] = ref_update(ref_mem[5], 4'b0100, -8'sd3);
        n_cmp++;
        if (mem[5] !== 32'h7F80_0304 || mem[5] !== ref_mem[5]) begin
            n_err++;
            $display("FAIL update_sat_lo: mem[5]=%h, required 7f800304 (model %h)", mem[5], ref_mem[5]);
        end
        we0 = we_cnt;
        issue(1'b1, 9'd6, 4'b0000, 8'h7F);
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0 || we_cnt !== we0 || mem[6] !== ref_mem[6]) begin
            n_err++;
            $display("FAIL update_mask0: busy=%b writes=%0d mem[6]=%h, required 0 %0d %h",
                     busy, we_cnt - we0, mem[6], 0, ref_mem[6]);
        end
    endtask

    task automatic test_back_to_back();
        int hs0, we0, first, t;
        hs0 = hs_cnt; we0 = we_cnt; first = -1; t = 0;
        req_op = 1'b1; req_addr = 9'd9; req_mask = 4'b0001; req_delta = 8'sd1;
        req_valid = 1'b1;
        while (hs_cnt < hs0 + 2 && t < 40) begin
            step();
            t++;
            if (first < 0 && hs_cnt == hs0 + 1) first = last_hs_cyc;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (last_hs_cyc - first !== 4) begin
            n_err++;
            $display("FAIL b2b_accept_gap: %0d cycles between accepts, required 4", last_hs_cyc - first);
        end
        wait_idle();
        ref_mem[9] = ref_update(ref_update(ref_mem[9], 4'b0001, 8'sd1), 4'b0001, 8'sd1);
        n_cmp++;
        if (cyc - first !== 8 || we_cnt - we0 !== 2) begin
            n_err++;
            $display("FAIL b2b_timing: total=%0d writes=%0d, required 8 2", cyc - first, we_cnt - we0);
        end
        n_cmp++;
        if (mem[9] !== 32'h0000_0002 || mem[9] !== ref_mem[9]) begin
            n_err++;
            $display("FAIL b2b_coherent: mem[9]=%h, required 00000002 (model %h)", mem[9], ref_mem[9]);
        end
    endtask

    task automatic test_oor();
        int cs0, rsp0, err0;
        cs0 = cs_cnt; rsp0 = rsp_cnt; err0 = err_cnt;
        issue(1'b0, 9'd300, 4'h0, 8'h00);
        n_cmp++;
        if (err_oor !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL oor_pulse: err_oor=%b busy=%b req_ready=%b, required 1 0 1", err_oor, busy, req_ready);
        end
        step();
        n_cmp++;
        if (err_oor !== 1'b0) begin
            n_err++;
            $display("FAIL oor_width: err_oor=%b in second cycle, required 0", err_oor);
        end
        issue(1'b1, 9'd256, 4'hF, 8'h10);
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (cs_cnt !== cs0 || rsp_cnt !== rsp0 || err_cnt - err0 !== 2) begin
            n_err++;
            $display("FAIL oor_side: cs_cycles=%0d rsp_cycles=%0d err_pulses=%0d, required 0 0 2",
                     cs_cnt - cs0, rsp_cnt - rsp0, err_cnt - err0);
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        we0 = we_cnt;
        issue(1'b1, 9'd20, 4'b1111, 8'sd5);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || CS !== 1'b0 || we_cnt !== we0 || mem[20] !== ref_mem[20]) begin
            n_err++;
            $display("FAIL rst_in_cap: busy=%b CS=%b writes=%0d mem[20]=%h, required 0 0 0 %h",
                     busy, CS, we_cnt - we0, mem[20], ref_mem[20]);
        end
        issue(1'b1, 9'd20, 4'b1010, -8'sd7);
        step();
        step();
        RST = 1'b1;
        step();
        ref_mem[20] = ref_update(ref_mem[20], 4'b1010, -8'sd7);
        n_cmp++;
        if (busy !== 1'b0 || CS !== 1'b0 || we_cnt - we0 !== 1 || mem[20] !== ref_mem[20]) begin
            n_err++;
            $display("FAIL rst_in_wr: busy=%b CS=%b writes=%0d mem[20]=%h, required 0 0 1 %h",
                     busy, CS, we_cnt - we0, mem[20], ref_mem[20]);
        end
        RST = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic       op;
        logic [8:0] addr;
        logic [3:0] mask;
        logic [7:0] delta;
        int         t, bad;
        for (int n = 0; n < 60; n++) begin
            op    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 9) == 0) ? 9'(256 + $urandom_range(0, 255))
                                                : 9'($urandom_range(0, 31));
            mask  = 4'($urandom);
            delta = 8'($urandom);
            issue(op, addr, mask, delta);
            if (addr >= 9'd256) begin
                n_cmp++;
                if (err_oor !== 1'b1 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_oor[%0d]: err_oor=%b busy=%b, required 1 0", n, err_oor, busy);
                end
            end else if (op == 1'b0) begin
                t = 0;
                while (rsp_valid !== 1'b1 && t < 10) begin
                    step();
                    t++;
                end
                n_cmp++;
                if (t !== 2 || rsp_data !== ref_mem[addr]) begin
                    n_err++;
                    $display("FAIL rand_read[%0d]: addr=%0d latency=%0d data=%h, required 2 %h",
                             n, addr, t, rsp_data, ref_mem[addr]);
                end
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
            end else begin
                ref_mem[addr] = ref_update(ref_mem[addr], mask, delta);
                wait_idle();
            end
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rand_mem_image: %0d words differ from model, required 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]  = 32'h7F80_0102; ref_mem[5]  = 32'h7F80_0102;
        mem[9]  = 32'h0000_0000; ref_mem[9]  = 32'h0000_0000;
        test_reset();
        test_read_hold();
        test_update();
        test_back_to_back();
        test_oor();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
